// File: rtl/text_render.sv
// Character-cell text renderer: raster position -> text RAM -> font ROM -> RGB pixel.
// Three-stage pipeline (address, RAM/font lookup, pixel) with inverse video and blinking cursor.
module text_render #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              de_i,
    input  logic [9:0]        hcount_i,
    input  logic [9:0]        vcount_i,
    input  logic              frame_start_i,
    input  logic              cursor_en_i,
    input  logic [6:0]        cursor_col_i,
    input  logic [5:0]        cursor_row_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [7:0]        ram_data_i,
    output logic [7:0]        font_ascii_o,
    output logic [3:0]        font_line_o,
    input  logic [7:0]        font_row_i,
    output logic [11:0]       rgb_o,
    output logic              de_out_o
);

    localparam logic [10:0] HPix = 11'(COLS * 8);
    localparam logic [10:0] VPix = 11'(ROWS * 8);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

    // Stage 0 state
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              v0_q, v0_d;
    logic [2:0]        x0_q, x0_d;
    logic [2:0]        y0_q, y0_d;
    logic              cur0_q, cur0_d;

    // Stage 1 state
    logic [3:0]        font_line_q, font_line_d;
    logic              v1_q, v1_d;
    logic [2:0]        x1_q, x1_d;
    logic              cur1_q, cur1_d;

    // Stage 2 state
    logic [11:0]       rgb_q, rgb_d;
    logic              de_out_q, de_out_d;

    // Cursor blink state
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;

    logic              in_range;
    logic [6:0]        cell_col;
    logic [6:0]        cell_row;
    logic [ADDR_W-1:0] cell_addr;
    logic              cur_hit;
    logic              glyph_bit;
    logic              pix;

    always_comb begin
        cell_col  = hcount_i[9:3];
        cell_row  = vcount_i[9:3];
        in_range  = de_i && ({1'b0, hcount_i} < HPix) && ({1'b0, vcount_i} < VPix);
        cell_addr = ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col);
        // In-range cells are always < COLS/ROWS, so an off-screen cursor can never match.
        cur_hit   = in_range && cursor_en_i && blink_on_q &&
                    (cell_col == cursor_col_i) && (cell_row == {1'b0, cursor_row_i}) &&
                    (vcount_i[2:0] >= 3'd6);
    end

    always_comb begin
        ram_addr_d = in_range ? cell_addr : ram_addr_q;
        v0_d       = in_range;
        x0_d       = hcount_i[2:0];
        y0_d       = vcount_i[2:0];
        cur0_d     = cur_hit;
    end

    always_comb begin
        font_line_d = {1'b0, y0_q};
        v1_d        = v0_q;
        x1_d        = x0_q;
        cur1_d      = cur0_q;
    end

    always_comb begin
        glyph_bit = font_row_i[3'd7 - x1_q];
        pix       = (glyph_bit ^ ram_data_i[7]) | cur1_q;
        rgb_d     = v1_q ? (pix ? FG : BG) : 12'h000;
        de_out_d  = v1_q;
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_start_i) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_addr_q  <= '0;
            v0_q        <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            cur0_q      <= 1'b0;
            font_line_q <= '0;
            v1_q        <= 1'b0;
            x1_q        <= '0;
            cur1_q      <= 1'b0;
            rgb_q       <= '0;
            de_out_q    <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            ram_addr_q  <= ram_addr_d;
            v0_q        <= v0_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            cur0_q      <= cur0_d;
            font_line_q <= font_line_d;
            v1_q        <= v1_d;
            x1_q        <= x1_d;
            cur1_q      <= cur1_d;
            rgb_q       <= rgb_d;
            de_out_q    <= de_out_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // The font ROM holds 128 glyphs; the inverse flag never reaches it.
    assign font_ascii_o = {1'b0, ram_data_i[6:0]};
    assign font_line_o  = font_line_q;
    assign ram_addr_o   = ram_addr_q;
    assign rgb_o        = rgb_q;
    assign de_out_o     = de_out_q;

endmodule

// File: tb/tb_text_render.sv
// Bench for text_render: models text RAM and font ROM, predicts every pixel from cell/glyph rules.
module tb_text_render;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int BF   = 2;
    localparam logic [11:0] FGC = 12'hFFF;
    localparam logic [11:0] BGC = 12'h000;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        frame_start;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [12:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  font_ascii;
    logic [3:0]  font_line;
    logic [7:0]  font_row;
    logic [11:0] rgb;
    logic        de_out;

    logic [7:0]  mem [0:8191];
    logic [12:0] e0, e1, e2;
    int          frames;
    logic        chk_en = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;
    logic [11:0] cap_q [$];

    always #5 clk = ~clk;

    text_render #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(13), .BLINK_FRAMES(BF), .FG(FGC), .BG(BGC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .de_i(de), .hcount_i(hcount), .vcount_i(vcount),
        .frame_start_i(frame_start), .cursor_en_i(cursor_en), .cursor_col_i(cursor_col),
        .cursor_row_i(cursor_row), .ram_addr_o(ram_addr), .ram_data_i(ram_data),
        .font_ascii_o(font_ascii), .font_line_o(font_line), .font_row_i(font_row),
        .rgb_o(rgb), .de_out_o(de_out)
    );

    function automatic logic [7:0] font_fn(input logic [7:0] a, input logic [3:0] l);
        if (a == 8'h41 && l < 4'd8) begin
            case (l[2:0])
                3'd0: return 8'h30;
                3'd1: return 8'h78;
                3'd2: return 8'hCC;
                3'd3: return 8'hCC;
                3'd4: return 8'hFC;
                3'd5: return 8'hCC;
                3'd6: return 8'hCC;
                default: return 8'h00;
            endcase
        end
        return 8'(a * 8'd13) ^ 8'({4'b0, l} * 8'd29) ^ 8'h5A;
    endfunction

    // Synchronous-read text RAM and combinational font ROM.
    always @(posedge clk) ram_data <= mem[ram_addr];
    assign font_row = font_fn(font_ascii, font_line);

    function automatic logic [12:0] expect_px(input logic d, input logic [9:0] h,
                                              input logic [9:0] v, input logic cen,
                                              input logic [6:0] cc, input logic [5:0] cr,
                                              input int nfr);
        int hi, vi, col, row;
        logic [7:0] code, glyph;
        logic bit_v, cur;
        hi = int'(h);
        vi = int'(v);
        if (!d || hi >= COLS * 8 || vi >= ROWS * 8) return 13'h0;
        col   = hi / 8;
        row   = vi / 8;
        code  = mem[row * COLS + col];
        glyph = font_fn({1'b0, code[6:0]}, 4'(vi % 8));
        bit_v = glyph[7 - (hi % 8)] ^ code[7];
        cur   = cen && (((nfr / BF) % 2) == 0) && (int'(cc) == col) && (int'(cr) == row) &&
                ((vi % 8) >= 6);
        return {1'b1, (bit_v | cur) ? FGC : BGC};
    endfunction

    // Expected {de_out, rgb} for the pixel sampled two edges earlier.
    always @(posedge clk) begin
        if (rst) begin
            e0 <= '0;
            e1 <= '0;
            e2 <= '0;
            frames <= 0;
        end else begin
            e0 <= expect_px(de, hcount, vcount, cursor_en, cursor_col, cursor_row, frames);
            e1 <= e0;
            e2 <= e1;
            frames <= frames + int'(frame_start);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_total++;
            if ({de_out, rgb} === e2) n_pass++;
            else $display("FAIL pipe t=%0t: de_out/rgb=%b/%h, want %b/%h",
                          $time, de_out, rgb, e2[12], e2[11:0]);
        end
        if (de_out === 1'b1) cap_q.push_back(rgb);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic drive(input logic d, input int h, input int v);
        de = d;
        hcount = 10'(h);
        vcount = 10'(v);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            de = 1'b0;
            @(negedge clk);
        end
    endtask

    logic [11:0] lit_norm [8] = '{BGC, BGC, FGC, FGC, BGC, BGC, BGC, BGC};
    logic [11:0] lit_inv  [8] = '{FGC, FGC, BGC, BGC, FGC, FGC, FGC, FGC};

    initial begin
        int k;
        logic all_fg;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        rst = 1'b1; de = 1'b1; hcount = '0; vcount = '0; frame_start = 1'b0;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

        // Reset held two clocks with de=1
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_de_out", 32'(de_out), 32'h0);
        check("reset_ram_addr", 32'(ram_addr), 32'h0);
        rst = 1'b0;
        k = 0;
        while (de_out !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("first_de_out_latency", 32'(k), 32'd3);
        idle(3);

        // Address mapping
        drive(1'b1, 0, 0);
        check("addr_0_0", 32'(ram_addr), 32'd0);
        drive(1'b1, 639, 479);
        check("addr_last_cell", 32'(ram_addr), 32'd4799);
        drive(1'b1, 8, 8);
        check("addr_8_8", 32'(ram_addr), 32'd81);
        drive(1'b1, 640, 0);
        check("addr_hold_out_of_range", 32'(ram_addr), 32'd81);
        idle(1);
        check("de_out_in_range", 32'(de_out), 32'd1);
        idle(1);
        check("de_out_out_of_range", 32'(de_out), 32'd0);
        check("rgb_out_of_range", 32'(rgb), 32'd0);
        idle(3);

        // Glyph row and its inverse
        mem[0] = 8'h41;
        idle(3);
        cap_q.delete();
        for (int x = 0; x < 8; x++) drive(1'b1, x, 0);
        idle(4);
        check("glyph_count", 32'(cap_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check($sformatf("glyph_px%0d", i), 32'(cap_q[i]), 32'(lit_norm[i]));
        check("font_ascii", 32'(font_ascii), 32'h41);
        check("font_line", 32'(font_line), 32'h0);
        mem[0] = 8'hC1;
        idle(3);
        cap_q.delete();
        for (int x = 0; x < 8; x++) drive(1'b1, x, 0);
        idle(4);
        check("inv_count", 32'(cap_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check($sformatf("inv_px%0d", i), 32'(cap_q[i]), 32'(lit_inv[i]));
        check("font_ascii_inv_stripped", 32'(font_ascii), 32'h41);

        // Cursor blink over frames at cell (2,1), glyph line 6
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem[82] = 8'h41;
        cursor_col = 7'd2;
        cursor_row = 6'd1;
        for (int f = 0; f < 10; f++) begin
            cursor_en = (f < 8);
            idle(2);
            cap_q.delete();
            for (int x = 0; x < 8; x++) drive(1'b1, 16 + x, 14);
            idle(4);
            all_fg = (cap_q.size() == 8);
            foreach (cap_q[i]) if (cap_q[i] !== FGC) all_fg = 1'b0;
            check($sformatf("cursor_frame%0d", f), 32'(all_fg),
                  32'((f < 8) && (((f / 2) % 2) == 0)));
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end

        // Back-to-back row of 80 cells with incrementing codes
        cursor_en = 1'b0;
        for (int c = 0; c < COLS; c++) mem[5 * COLS + c] = 8'(c);
        idle(3);
        cap_q.delete();
        for (int h = 0; h < 640; h++) drive(1'b1, h, 43);
        idle(4);
        check("b2b_count", 32'(cap_q.size()), 32'd640);
        if (cap_q.size() == 640) begin
            check("b2b_cell65_px0", 32'(cap_q[520]), 32'(FGC));
            check("b2b_cell65_px2", 32'(cap_q[522]), 32'(BGC));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        idle(3);
        for (int n = 0; n < 5000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            frame_start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) < 3) begin
                cursor_en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    cursor_col = 7'($urandom_range(0, 5));
                    cursor_row = 6'($urandom_range(0, 2));
                end else begin
                    cursor_col = 7'($urandom);
                    cursor_row = 6'($urandom);
                end
            end
            if ($urandom_range(0, 9) < 6)
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 47), $urandom_range(0, 23));
            else
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        rst = 1'b0;
        frame_start = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
